// File: rtl/reg_wb_arb.sv
// Register-file write-back arbiter. It merges unstallable ALU results with buffered multiply/divide results,
// and it keeps a pending-write scoreboard for MDU destinations.
module reg_wb_arb #(
    parameter int MDU_FIFO_DEPTH = 2
) (
    input  logic        ip_clk,
    input  logic        ip_rst_n,
    input  logic        ip_alu_valid,
    input  logic [4:0]  ip_alu_rd,
    input  logic [31:0] ip_alu_data,
    input  logic        ip_mdu_valid,
    input  logic [4:0]  ip_mdu_rd,
    input  logic [31:0] ip_mdu_data,
    output logic        op_mdu_ready,
    input  logic        ip_iss_en,
    input  logic        ip_iss_mdu,
    input  logic [4:0]  ip_iss_rd,
    input  logic [4:0]  ip_rs1_addr,
    input  logic [4:0]  ip_rs2_addr,
    output logic        op_rs1_busy,
    output logic        op_rs2_busy,
    output logic        op_wr_en,
    output logic [4:0]  op_wr_addr,
    output logic [31:0] op_wr_data
);
    localparam int PW = $clog2(MDU_FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    fifo_rd_q   [MDU_FIFO_DEPTH];
    logic [4:0]    fifo_rd_d   [MDU_FIFO_DEPTH];
    logic [31:0]   fifo_data_q [MDU_FIFO_DEPTH];
    logic [31:0]   fifo_data_d [MDU_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   busy_q, busy_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          armed_q, armed_d;

    logic          push;
    logic          pop;
    logic          sel_valid;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;

    always_comb begin
        op_mdu_ready = ip_rst_n && (count_q < CW'(MDU_FIFO_DEPTH));
        push         = ip_mdu_valid && op_mdu_ready;
        pop          = !ip_alu_valid && (count_q != '0);
        sel_valid    = ip_alu_valid || pop;
        sel_rd       = ip_alu_valid ? ip_alu_rd   : fifo_rd_q[rd_ptr_q];
        sel_data     = ip_alu_valid ? ip_alu_data : fifo_data_q[rd_ptr_q];

        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = ip_mdu_rd;
            fifo_data_d[wr_ptr_q] = ip_mdu_data;
        end
        // Depth is a power of two, so natural pointer overflow gives modulo wrap.
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        // The first edge after reset release never produces a write.
        wr_en_d   = sel_valid && (sel_rd != 5'd0) && armed_q;
        wr_addr_d = wr_en_d ? sel_rd   : wr_addr_q;
        wr_data_d = wr_en_d ? sel_data : wr_data_q;
        armed_d   = 1'b1;

        // The clear is applied before the set, so a same-cycle issue to the same rd keeps the bit set.
        busy_d = busy_q;
        if (pop) begin
            busy_d[fifo_rd_q[rd_ptr_q]] = 1'b0;
        end
        if (ip_iss_en && ip_iss_mdu && (ip_iss_rd != 5'd0)) begin
            busy_d[ip_iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n) begin
            for (int i = 0; i < MDU_FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            armed_q     <= armed_d;
        end
    end

    assign op_rs1_busy = busy_q[ip_rs1_addr];
    assign op_rs2_busy = busy_q[ip_rs2_addr];
    assign op_wr_en    = wr_en_q;
    assign op_wr_addr  = wr_addr_q;
    assign op_wr_data  = wr_data_q;

endmodule

// File: tb/tb_reg_wb_arb.sv
// Scoreboard bench for reg_wb_arb: a reference model queues expected writes, and a negedge monitor pops them.
module tb_reg_wb_arb;
    localparam int DEPTH = 2;

    logic        ip_clk = 1'b0;
    logic        ip_rst_n = 1'b0;
    logic        ip_alu_valid = 1'b0;
    logic [4:0]  ip_alu_rd = '0;
    logic [31:0] ip_alu_data = '0;
    logic        ip_mdu_valid = 1'b0;
    logic [4:0]  ip_mdu_rd = '0;
    logic [31:0] ip_mdu_data = '0;
    logic        op_mdu_ready;
    logic        ip_iss_en = 1'b0;
    logic        ip_iss_mdu = 1'b0;
    logic [4:0]  ip_iss_rd = '0;
    logic [4:0]  ip_rs1_addr = '0;
    logic [4:0]  ip_rs2_addr = '0;
    logic        op_rs1_busy;
    logic        op_rs2_busy;
    logic        op_wr_en;
    logic [4:0]  op_wr_addr;
    logic [31:0] op_wr_data;

    always #5 ip_clk = ~ip_clk;

    reg_wb_arb #(.MDU_FIFO_DEPTH(DEPTH)) dut (
        .ip_clk       (ip_clk),
        .ip_rst_n     (ip_rst_n),
        .ip_alu_valid (ip_alu_valid),
        .ip_alu_rd    (ip_alu_rd),
        .ip_alu_data  (ip_alu_data),
        .ip_mdu_valid (ip_mdu_valid),
        .ip_mdu_rd    (ip_mdu_rd),
        .ip_mdu_data  (ip_mdu_data),
        .op_mdu_ready (op_mdu_ready),
        .ip_iss_en    (ip_iss_en),
        .ip_iss_mdu   (ip_iss_mdu),
        .ip_iss_rd    (ip_iss_rd),
        .ip_rs1_addr  (ip_rs1_addr),
        .ip_rs2_addr  (ip_rs2_addr),
        .op_rs1_busy  (op_rs1_busy),
        .op_rs2_busy  (op_rs2_busy),
        .op_wr_en     (op_wr_en),
        .op_wr_addr   (op_wr_addr),
        .op_wr_data   (op_wr_data)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];
    ent_t        mdu_model_q[$];
    logic [31:0] busy_model = '0;
    int          cyc = 0;
    bit          armed = 0;
    int          tests = 0;
    int          fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: the model decides what the DUT must do at the coming edge.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
        ent_t        e;
        bit          have = 0;
        bit          popped = 0;
        bit          mready;
        logic [4:0]  srd = '0;
        logic [31:0] sd = '0;
        ip_alu_valid = av;
        ip_alu_rd    = ar;
        ip_alu_data  = ad;
        ip_mdu_valid = mv;
        ip_mdu_rd    = mr;
        ip_mdu_data  = md;
        @(negedge ip_clk);
        mready = (mdu_model_q.size() < DEPTH);
        check_eq("mdu_ready", op_mdu_ready, mready);
        check_eq("rs1_busy", op_rs1_busy, busy_model[ip_rs1_addr]);
        check_eq("rs2_busy", op_rs2_busy, busy_model[ip_rs2_addr]);
        if (av) begin
            have = 1; srd = ar; sd = ad;
        end else if (mdu_model_q.size() > 0) begin
            e = mdu_model_q.pop_front();
            have = 1; popped = 1; srd = e.rd; sd = e.data;
        end
        if (have && srd != 5'd0 && armed) begin
            e.cyc = cyc + 1; e.rd = srd; e.data = sd;
            exp_q.push_back(e);
        end
        if (mv && mready) begin
            e.cyc = 0; e.rd = mr; e.data = md;
            mdu_model_q.push_back(e);
        end
        if (popped) busy_model[srd] = 1'b0;
        if (ip_iss_en && ip_iss_mdu && ip_iss_rd != 5'd0) busy_model[ip_iss_rd] = 1'b1;
        @(posedge ip_clk);
        cyc++;
        armed = 1;
        #1;
        ip_iss_en    = 1'b0;
        ip_iss_mdu   = 1'b0;
        ip_alu_valid = 1'b0;
        ip_mdu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic issue(input logic [4:0] rd);
        ip_iss_en  = 1'b1;
        ip_iss_mdu = 1'b1;
        ip_iss_rd  = rd;
    endtask

    task automatic do_reset();
        ip_rst_n = 1'b0;
        #1;
        check_eq("rst_wr_en", op_wr_en, 1'b0);
        check_eq("rst_wr_addr", op_wr_addr, 5'd0);
        check_eq("rst_wr_data", op_wr_data, 32'd0);
        check_eq("rst_mdu_ready", op_mdu_ready, 1'b0);
        check_eq("rst_rs1_busy", op_rs1_busy, 1'b0);
        check_eq("rst_rs2_busy", op_rs2_busy, 1'b0);
        mdu_model_q.delete();
        exp_q.delete();
        busy_model = '0;
        @(posedge ip_clk);
        cyc++;
        #1;
        ip_rst_n = 1'b1;
        armed = 0;
    endtask

    // Monitor: every write must match the oldest expected entry in address, data and cycle.
    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge ip_clk);
            if (op_wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_wr", op_wr_en, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] cyc %0d write x%0d = 0x%08h", cyc, op_wr_addr, op_wr_data);
                    check_eq("wr_addr", op_wr_addr, e.rd);
                    check_eq("wr_data", op_wr_data, e.data);
                    check_eq("wr_cycle", cyc, e.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                check_eq("missing_wr", op_wr_en, 1'b1);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        #1;
        ip_rs1_addr = 5'd4;
        ip_rs2_addr = 5'd0;
        do_reset();
        idle(2);

        // Single ALU write: one-cycle pulse, then idle.
        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        check_eq("alu_wr_en", op_wr_en, 1'b1);
        check_eq("alu_wr_addr", op_wr_addr, 5'd5);
        check_eq("alu_wr_data", op_wr_data, 32'h1234_5678);
        idle(1);
        check_eq("alu_pulse_end", op_wr_en, 1'b0);
        check_eq("hold_addr", op_wr_addr, 5'd5);

        // The MDU result waits behind three ALU writes.
        step(1'b1, 5'd3, 32'h0000_0031, 1'b1, 5'd7, 32'hAAAA_0000);
        step(1'b1, 5'd3, 32'h0000_0032, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'd0);
        idle(3);

        // Full buffer: the third offer is held off until a pop frees space.
        step(1'b1, 5'd11, 32'h0B0B_0001, 1'b1, 5'd8,  32'h0808_0808);
        step(1'b1, 5'd11, 32'h0B0B_0002, 1'b1, 5'd9,  32'h0909_0909);
        step(1'b1, 5'd11, 32'h0B0B_0003, 1'b1, 5'd10, 32'h1010_1010);
        step(1'b1, 5'd11, 32'h0B0B_0004, 1'b1, 5'd10, 32'h1010_1010);
        step(1'b0, 5'd0,  32'd0,         1'b1, 5'd10, 32'h1010_1010);
        step(1'b0, 5'd0,  32'd0,         1'b1, 5'd10, 32'h1010_1010);
        idle(3);

        // Scoreboard set and clear for x12; an issue to x0 never marks busy.
        ip_rs1_addr = 5'd12;
        ip_rs2_addr = 5'd0;
        issue(5'd12);
        idle(2);
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC0C0_C0C0);
        idle(3);
        issue(5'd0);
        idle(2);

        // An MDU result for x0 is consumed without a write.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        idle(3);

        // Reset with buffered results and busy x4: everything is discarded.
        ip_rs1_addr = 5'd4;
        ip_rs2_addr = 5'd20;
        issue(5'd4);
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd4,  32'h4444_4444);
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd20, 32'h2020_2020);
        do_reset();
        step(1'b1, 5'd6, 32'h6666_6666, 1'b0, 5'd0, 32'd0);
        check_eq("no_wr_after_release", op_wr_en, 1'b0);
        idle(3);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            ip_rs1_addr = 5'($urandom_range(0, 31));
            ip_rs2_addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) issue(5'($urandom_range(0, 31)));
            step(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), 32'($urandom()),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 32'($urandom()));
        end
        idle(6);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_wb_arb.md
REG_WB_ARB -- requirements
Module: reg_wb_arb

Interface
REQ-001 Parameter: MDU_FIFO_DEPTH, default 2, entries in the multiply/divide result buffer; legal values 2 or 4.
REQ-002 ip_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 ip_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ip_alu_valid  input  1  single-cycle ALU/load result present this cycle; cannot be stalled.
REQ-005 ip_alu_rd  input  5  ALU result destination register.
REQ-006 ip_alu_data  input  32  ALU result data.
REQ-007 ip_mdu_valid  input  1  multiply/divide result offered.
REQ-008 ip_mdu_rd  input  5  MDU result destination register.
REQ-009 ip_mdu_data  input  32  MDU result data.
REQ-010 op_mdu_ready  output  1  buffer can accept an MDU result this cycle.
REQ-011 ip_iss_en  input  1  instruction issued this cycle.
REQ-012 ip_iss_mdu  input  1  issued instruction is multiply/divide (qualifies ip_iss_en).
REQ-013 ip_iss_rd  input  5  issued instruction destination.
REQ-014 ip_rs1_addr, ip_rs2_addr  input  5 each  operand addresses for hazard query.
REQ-015 op_rs1_busy, op_rs2_busy  output  1 each  queried register has an MDU write pending.
REQ-016 op_wr_en  output  1  register-file write enable.
REQ-017 op_wr_addr  output  5  register-file write address.
REQ-018 op_wr_data  output  32  register-file write data.

Function
REQ-019 The block SHALL drive at most one register-file write per cycle; op_wr_en, op_wr_addr, op_wr_data SHALL be registered, updated on the edge following selection (1-cycle latency), op_wr_en high for exactly one cycle per write.
REQ-020 Selection priority: ALU result when ip_alu_valid=1; otherwise FIFO head when FIFO non-empty; otherwise op_wr_en=0 next cycle with op_wr_addr/op_wr_data holding previous values.
REQ-021 MDU push SHALL occur at an edge where ip_mdu_valid=1 and op_mdu_ready=1; push while not ready SHALL be ignored (no overflow, no data corruption).
REQ-022 op_mdu_ready SHALL be combinational: 1 when FIFO occupancy < MDU_FIFO_DEPTH and ip_rst_n=1; it SHALL NOT depend on a same-cycle pop.
REQ-023 FIFO SHALL be in-order; pointers wrap modulo MDU_FIFO_DEPTH; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-024 No bypass: a result pushed into an empty FIFO SHALL be written no earlier than 2 edges after the push edge.
REQ-025 Destination 0: the selected entry SHALL be consumed (ALU accepted or FIFO popped) but op_wr_en SHALL remain 0.
REQ-026 Scoreboard: 32-bit busy vector; bit rd set at edge where ip_iss_en=1, ip_iss_mdu=1, ip_iss_rd!=0.
REQ-027 busy[rd] cleared at the edge where a FIFO entry with that rd is selected for write; if set and clear target the same bit in one cycle, set SHALL win.
REQ-028 busy[0] SHALL always read 0.
REQ-029 op_rs1_busy = busy[ip_rs1_addr], op_rs2_busy = busy[ip_rs2_addr], combinational.
REQ-030 An ALU write to a register with busy=1 SHALL still be performed and SHALL NOT clear busy (WAW ordering is the issue stage's responsibility).

Reset
REQ-031 While ip_rst_n=0: op_wr_en=0, op_wr_addr=0, op_wr_data=0, busy vector=0, FIFO empty, op_mdu_ready=0, op_rs1_busy=op_rs2_busy=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered MDU results and pending busy bits immediately; no write SHALL issue on the first edge after release.

Verification
REQ-033 ALU only: ip_alu_valid=1, rd=5, data=0x12345678 -> next cycle op_wr_en=1, op_wr_addr=5, op_wr_data=0x12345678, following cycle op_wr_en=0.
REQ-034 Conflict: MDU rd=7 data=0xAAAA0000 pushed while ALU writes rd=3 for 3 consecutive cycles -> writes to x3 x3 x3 then x7 on 4th write cycle, data intact.
REQ-035 Full: DEPTH=2, push rd=8,9 with ALU busy -> op_mdu_ready=0, third offer rd=10 ignored until a pop; final write order 8,9,10.
REQ-036 Scoreboard: issue MDU rd=12 -> op_rs1_busy=1 for ip_rs1_addr=12 next cycle; clears at edge x12 is written; issue rd=0 -> busy never set.
REQ-037 rd=0 result: MDU push rd=0 data=0xFFFFFFFF -> FIFO drains, op_wr_en never asserted.
REQ-038 Reset mid-flight: two FIFO entries and busy[4]=1, pulse ip_rst_n low -> all outputs 0, no write after release, op_mdu_ready=1 after release.
